// File: rtl/pid_update_scheduler.sv
// Round-robin grant of one shared PID datapath across motor channels, with a
// start/done handshake, a WAIT timeout watchdog and sticky error/overrun status.
module pid_update_scheduler #(
    parameter int NUMBER_OF_MOTORS = 8,
    parameter int CHANNEL_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic                        clock_i,
    input  logic                        reset_n_i,
    input  logic [NUMBER_OF_MOTORS-1:0] update_request_i,
    input  logic [NUMBER_OF_MOTORS-1:0] enable_mask_i,
    input  logic                        hold_i,
    input  logic                        flush_i,
    input  logic                        clear_errors_i,
    input  logic                        done_i,
    output logic                        start_o,
    output logic [CHANNEL_WIDTH-1:0]    channel_o,
    output logic                        busy_o,
    output logic [NUMBER_OF_MOTORS-1:0] pending_o,
    output logic                        timeout_error_o,
    output logic [CHANNEL_WIDTH-1:0]    timeout_channel_o,
    output logic [15:0]                 overrun_count_o
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    localparam logic [15:0]              WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [CHANNEL_WIDTH-1:0] LAST_CH   = CHANNEL_WIDTH'(NUMBER_OF_MOTORS - 1);

    state_t                      state_q;
    logic                        start_q;
    logic                        busy_q;
    logic [CHANNEL_WIDTH-1:0]    channel_q;
    logic [CHANNEL_WIDTH-1:0]    last_channel_q;
    logic [NUMBER_OF_MOTORS-1:0] pending_q, pending_d;
    logic                        timeout_error_q;
    logic [CHANNEL_WIDTH-1:0]    timeout_channel_q;
    logic [15:0]                 overrun_count_q, overrun_count_d;
    logic [15:0]                 wait_cnt_q;

    logic [NUMBER_OF_MOTORS-1:0] eligible;
    logic [NUMBER_OF_MOTORS-1:0] grant_vec;
    logic [CHANNEL_WIDTH-1:0]    sel;
    logic                        sel_vld;
    logic                        grant;
    logic [16:0]                 ovr_hits;
    logic [16:0]                 ovr_sum;

    function automatic logic [CHANNEL_WIDTH-1:0] rr_idx(input logic [CHANNEL_WIDTH-1:0] base,
                                                        input int offs);
        int v;
        v = int'(base) + offs;
        if (v >= NUMBER_OF_MOTORS) v = v - NUMBER_OF_MOTORS;
        return CHANNEL_WIDTH'(v);
    endfunction

    assign eligible = pending_q & enable_mask_i;

    // Scan offsets from farthest to nearest so the nearest eligible index after last_channel wins.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = NUMBER_OF_MOTORS; i >= 1; i--) begin
            if (eligible[rr_idx(last_channel_q, i)]) begin
                sel     = rr_idx(last_channel_q, i);
                sel_vld = 1'b1;
            end
        end
    end

    assign grant = (state_q == IDLE) && !hold_i && sel_vld;

    always_comb begin
        grant_vec = '0;
        if (grant) grant_vec[sel] = 1'b1;
    end

    // A request re-arms its bit even while the grant clears it; only that case is not an overrun.
    always_comb begin
        pending_d = pending_q;
        ovr_hits  = '0;
        for (int b = 0; b < NUMBER_OF_MOTORS; b++) begin
            if (flush_i) begin
                pending_d[b] = 1'b0;
            end else if (update_request_i[b]) begin
                pending_d[b] = 1'b1;
                if (pending_q[b] && !grant_vec[b]) ovr_hits = ovr_hits + 17'd1;
            end else if (grant_vec[b]) begin
                pending_d[b] = 1'b0;
            end
        end
    end

    assign ovr_sum = {1'b0, overrun_count_q} + ovr_hits;

    always_comb begin
        overrun_count_d = (ovr_sum > 17'h0FFFF) ? 16'hFFFF : ovr_sum[15:0];
        if (clear_errors_i) overrun_count_d = '0;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q           <= IDLE;
            start_q           <= 1'b0;
            busy_q            <= 1'b0;
            channel_q         <= '0;
            last_channel_q    <= LAST_CH;
            pending_q         <= '0;
            timeout_error_q   <= 1'b0;
            timeout_channel_q <= '0;
            overrun_count_q   <= '0;
            wait_cnt_q        <= '0;
        end else begin
            pending_q       <= pending_d;
            overrun_count_q <= overrun_count_d;
            start_q         <= 1'b0;
            if (clear_errors_i) begin
                timeout_error_q   <= 1'b0;
                timeout_channel_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q        <= START;
                        start_q        <= 1'b1;
                        busy_q         <= 1'b1;
                        channel_q      <= sel;
                        last_channel_q <= sel;
                    end
                end
                START: begin
                    state_q    <= WAIT;
                    wait_cnt_q <= '0;
                end
                WAIT: begin
                    if (done_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Abort assignments follow the clear above, so a same-cycle abort stays sticky.
                        state_q           <= IDLE;
                        busy_q            <= 1'b0;
                        timeout_error_q   <= 1'b1;
                        timeout_channel_q <= channel_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_o           = start_q;
    assign channel_o         = channel_q;
    assign busy_o            = busy_q;
    assign pending_o         = pending_q;
    assign timeout_error_o   = timeout_error_q;
    assign timeout_channel_o = timeout_channel_q;
    assign overrun_count_o   = overrun_count_q;

endmodule

// File: tb/tb_pid_update_scheduler.sv
// Bench for pid_update_scheduler: directed scenarios plus random traffic against a cycle model.
module tb_pid_update_scheduler;

    localparam int N  = 8;
    localparam int CW = 3;
    localparam int TO = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  mask  = '1;
    logic          hold  = 1'b0;
    logic          flush = 1'b0;
    logic          clr   = 1'b0;
    logic          done  = 1'b0;

    logic          start;
    logic [CW-1:0] chan;
    logic          busy;
    logic [N-1:0]  pend;
    logic          terr;
    logic [CW-1:0] tch;
    logic [15:0]   ovr;

    int checks = 0;
    int fails  = 0;

    pid_update_scheduler #(
        .NUMBER_OF_MOTORS(N),
        .CHANNEL_WIDTH   (CW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock_i          (clk),
        .reset_n_i        (rst_n),
        .update_request_i (req),
        .enable_mask_i    (mask),
        .hold_i           (hold),
        .flush_i          (flush),
        .clear_errors_i   (clr),
        .done_i           (done),
        .start_o          (start),
        .channel_o        (chan),
        .busy_o           (busy),
        .pending_o        (pend),
        .timeout_error_o  (terr),
        .timeout_channel_o(tch),
        .overrun_count_o  (ovr)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 start, 2 wait.
    int       m_state = 0;
    int       m_last  = N - 1;
    int       m_chan  = 0;
    int       m_cnt   = 0;
    int       m_tch   = 0;
    int       m_ovr   = 0;
    bit       m_err   = 1'b0;
    bit [N-1:0] m_pend = '0;

    task automatic model_reset();
        m_state = 0; m_last = N - 1; m_chan = 0; m_cnt = 0;
        m_tch = 0; m_ovr = 0; m_err = 1'b0; m_pend = '0;
    endtask

    task automatic model_step();
        int sel;
        int inc;
        bit [N-1:0] elig, gv, np;
        sel = -1; inc = 0; gv = '0; np = m_pend;
        elig = m_pend & mask;
        if (m_state == 0 && !hold && elig != 0) begin
            for (int i = 1; i <= N; i++)
                if (sel < 0 && elig[(m_last + i) % N]) sel = (m_last + i) % N;
            gv[sel] = 1'b1;
        end
        for (int b = 0; b < N; b++) begin
            if (flush) np[b] = 1'b0;
            else if (req[b]) begin
                np[b] = 1'b1;
                if (m_pend[b] && !gv[b]) inc++;
            end else if (gv[b]) np[b] = 1'b0;
        end
        m_pend = np;
        m_ovr  = clr ? 0 : ((m_ovr + inc > 65535) ? 65535 : m_ovr + inc);
        if (clr) begin m_err = 1'b0; m_tch = 0; end
        case (m_state)
            0: if (sel >= 0) begin m_state = 1; m_chan = sel; m_last = sel; end
            1: begin m_state = 2; m_cnt = 0; end
            default: begin
                if (done) m_state = 0;
                else if (m_cnt == TO - 1) begin m_state = 0; m_err = 1'b1; m_tch = m_chan; end
                else m_cnt++;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    wire [32:0] dut_vec = {start, chan, busy, pend, terr, tch, ovr};

    function automatic logic [32:0] exp_vec();
        return {m_state == 1, 3'(m_chan), m_state != 0, m_pend, m_err, 3'(m_tch), 16'(m_ovr)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; req = '0; mask = '1; hold = 1'b0; flush = 1'b0; clr = 1'b0; done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec !== 33'd0) begin
            fails++; $display("FAIL reset_values dut=%h exp=%h", dut_vec, 33'd0);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL reset_model dut=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_single_request();
        int busy_cycles = 0;
        done = 1'b1;
        req  = 8'h04;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            if (t == 1) req = '0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL single_model t=%0d dut=%h exp=%h", t, dut_vec, exp_vec());
            end
            if (busy) busy_cycles++;
            if (t == 1) begin
                checks++;
                if (pend !== 8'h04 || start !== 1'b0) begin
                    fails++; $display("FAIL single_pending pend=%h start=%b exp pend=04 start=0", pend, start);
                end
            end
            if (t == 2) begin
                checks++;
                if (start !== 1'b1 || chan !== 3'd2) begin
                    fails++; $display("FAIL single_start start=%b chan=%0d exp start=1 chan=2", start, chan);
                end
            end
        end
        checks++;
        if (busy_cycles != 2 || pend !== 8'h00) begin
            fails++; $display("FAIL single_busy busy_cycles=%0d pend=%h exp 2 and 00", busy_cycles, pend);
        end
        done = 1'b0;
    endtask

    task automatic test_round_robin();
        int sc[$];
        int st[$];
        do_reset();
        done = 1'b1;
        req  = 8'hFF;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (t == 1) req = '0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL rr_model t=%0d dut=%h exp=%h", t, dut_vec, exp_vec());
            end
            if (start) begin sc.push_back(int'(chan)); st.push_back(t); end
        end
        checks++;
        if (sc.size() != 8) begin
            fails++; $display("FAIL rr_count grants=%0d exp 8", sc.size());
        end
        for (int i = 0; i < sc.size() && i < 8; i++) begin
            checks++;
            if (sc[i] != i) begin
                fails++; $display("FAIL rr_order idx=%0d chan=%0d exp %0d", i, sc[i], i);
            end
            if (i > 0) begin
                checks++;
                if (st[i] - st[i-1] != 3) begin
                    fails++; $display("FAIL rr_spacing idx=%0d gap=%0d exp 3", i, st[i] - st[i-1]);
                end
            end
        end
        sc.delete(); st.delete();
        req = 8'h81;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (t == 1) req = '0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL rr_wrap_model t=%0d dut=%h exp=%h", t, dut_vec, exp_vec());
            end
            if (start) sc.push_back(int'(chan));
        end
        checks++;
        if (sc.size() != 2 || sc[0] != 0 || sc[1] != 7) begin
            fails++; $display("FAIL rr_wrap grants=%0d first=%0d exp 2 grants 0 then 7",
                              sc.size(), (sc.size() > 0) ? sc[0] : -1);
        end
        done = 1'b0;
    endtask

    task automatic test_mask_hold();
        int nstart = 0;
        int gch    = -1;
        do_reset();
        done = 1'b1;
        mask = 8'h02;
        req  = 8'h03;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (t == 1) req = '0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL mask_model t=%0d dut=%h exp=%h", t, dut_vec, exp_vec());
            end
            if (start) begin nstart++; gch = int'(chan); end
        end
        checks++;
        if (nstart != 1 || gch != 1 || pend !== 8'h01) begin
            fails++; $display("FAIL mask_grant starts=%0d chan=%0d pend=%h exp 1 start chan 1 pend 01",
                              nstart, gch, pend);
        end
        hold = 1'b1;
        mask = 8'hFF;
        nstart = 0;
        repeat (6) begin
            @(negedge clk);
            if (start) nstart++;
        end
        checks++;
        if (nstart != 0) begin
            fails++; $display("FAIL hold_blocks starts=%0d exp 0", nstart);
        end
        hold = 1'b0;
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || chan !== 3'd0) begin
            fails++; $display("FAIL hold_release start=%b chan=%0d exp start=1 chan=0", start, chan);
        end
        repeat (3) @(negedge clk);
        done = 1'b0;
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            int waits = 0;
            bit seen  = 1'b0;
            bit ended = 1'b0;
            if (pass == 1) begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                checks++;
                if (terr !== 1'b0 || tch !== 3'd0) begin
                    fails++; $display("FAIL clear_errors terr=%b tch=%0d exp 0 0", terr, tch);
                end
            end else begin
                do_reset();
            end
            done = 1'b0;
            req  = 8'h20;
            for (int t = 1; t <= 20 && !ended; t++) begin
                @(negedge clk);
                if (t == 1) req = '0;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    fails++; $display("FAIL timeout_model pass=%0d t=%0d dut=%h exp=%h", pass, t, dut_vec, exp_vec());
                end
                if (busy && !start) waits++;
                if (busy) seen = 1'b1;
                else if (seen) ended = 1'b1;
                if (pass == 1) done = (waits == 4) && busy;
            end
            done = 1'b0;
            checks++;
            if (!ended) begin
                fails++; $display("FAIL timeout_bound pass=%0d busy=%b exp grant finished within 20 cycles", pass, busy);
            end
            checks++;
            if (waits != 4) begin
                fails++; $display("FAIL timeout_wait_cycles pass=%0d waits=%0d exp 4", pass, waits);
            end
            checks++;
            if (pass == 0 && (terr !== 1'b1 || tch !== 3'd5)) begin
                fails++; $display("FAIL timeout_abort terr=%b tch=%0d exp 1 5", terr, tch);
            end else if (pass == 1 && terr !== 1'b0) begin
                fails++; $display("FAIL timeout_done_wins terr=%b exp 0", terr);
            end
        end
    endtask

    task automatic test_overrun_flush();
        do_reset();
        done = 1'b0;
        req  = 8'h01;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (t == 1) req = 8'h08;
            if (t == 4) begin req = '0; hold = 1'b1; end
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL overrun_model t=%0d dut=%h exp=%h", t, dut_vec, exp_vec());
            end
            if (t == 4) begin
                checks++;
                if (ovr !== 16'd2) begin
                    fails++; $display("FAIL overrun_count ovr=%0d exp 2", ovr);
                end
            end
        end
        checks++;
        if (pend !== 8'h08 || busy !== 1'b0) begin
            fails++; $display("FAIL overrun_held pend=%h busy=%b exp 08 0", pend, busy);
        end
        flush = 1'b1;
        req   = 8'hFF;
        @(negedge clk);
        flush = 1'b0;
        req   = '0;
        checks++;
        if (pend !== 8'h00 || ovr !== 16'd2) begin
            fails++; $display("FAIL flush_drops pend=%h ovr=%0d exp 00 2", pend, ovr);
        end
        req = 8'h08;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        req = '0;
        checks++;
        if (ovr !== 16'd0 || terr !== 1'b0 || pend !== 8'h08) begin
            fails++; $display("FAIL clear_vs_overrun ovr=%0d terr=%b pend=%h exp 0 0 08", ovr, terr, pend);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL clear_model dut=%h exp=%h", dut_vec, exp_vec());
        end
        hold = 1'b0;
        done = 1'b1;
        repeat (4) @(negedge clk);
        done = 1'b0;
    endtask

    task automatic test_async_reset();
        bit in_wait = 1'b0;
        bit got     = 1'b0;
        do_reset();
        done = 1'b0;
        req  = 8'h18;
        for (int t = 1; t <= 10 && !in_wait; t++) begin
            @(negedge clk);
            if (t == 1) req = '0;
            in_wait = busy && !start;
        end
        checks++;
        if (!in_wait) begin
            fails++; $display("FAIL async_reach_wait busy=%b start=%b exp WAIT within 10 cycles", busy, start);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || start !== 1'b0 || pend !== 8'h00) begin
            fails++; $display("FAIL async_reset busy=%b start=%b pend=%h exp 0 0 00", busy, start, pend);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done  = 1'b1;
        req   = 8'hFF;
        for (int t = 1; t <= 10 && !got; t++) begin
            @(negedge clk);
            if (t == 1) req = '0;
            if (start) begin
                got = 1'b1;
                checks++;
                if (chan !== 3'd0) begin
                    fails++; $display("FAIL async_first_grant chan=%0d exp 0", chan);
                end
            end
        end
        checks++;
        if (!got) begin
            fails++; $display("FAIL async_grant_bound start=%b exp a start within 10 cycles", start);
        end
        repeat (25) @(negedge clk);
        done = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL random_model t=%0d dut=%h exp=%h", t, dut_vec, exp_vec());
            end
            req   = N'($urandom & $urandom & $urandom);
            mask  = N'($urandom | $urandom);
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 31) == 0);
            clr   = ($urandom_range(0, 31) == 0);
            done  = ($urandom_range(0, 2) == 0);
        end
        req = '0; hold = 1'b0; flush = 1'b0; clr = 1'b0; done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t exp bench completion", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single_request();
        test_round_robin();
        test_mask_hold();
        test_timeout();
        test_overrun_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
